// File: rtl/mem_if_pkg.sv
// Shared definitions for the core data bus responder: bus widths, the error
// read pattern, the response record carried through the latency pipeline,
// grant FSM states and a byte-lane merge helper.
package mem_if_pkg;

    localparam int DATA_ADDR_WIDTH = 32;
    localparam int DATA_WORD_WIDTH = 32;
    localparam int DATA_BYTES      = DATA_WORD_WIDTH / 8;

    localparam logic [DATA_WORD_WIDTH-1:0] ERR_RDATA = 32'hDEAD_BEEF;

    // One response as it travels from the accept edge to rvalid_o.
    typedef struct packed {
        logic [DATA_WORD_WIDTH-1:0] rdata;
        logic                       err;
    } resp_t;

    // Grant FSM states (used only when grant wait states are configured).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } gnt_state_e;

    // Replace the byte lanes of old_word selected by be with those of wr_word.
    function automatic logic [DATA_WORD_WIDTH-1:0] merge_bytes(
        input logic [DATA_WORD_WIDTH-1:0] old_word,
        input logic [DATA_WORD_WIDTH-1:0] wr_word,
        input logic [DATA_BYTES-1:0]      be
    );
        logic [DATA_WORD_WIDTH-1:0] merged;
        merged = old_word;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = wr_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/resp_delay_line.sv
// Fixed-latency response pipeline: a valid bit plus a response record shift
// through LAT stages. Payload is zeroed whenever its valid bit is low, so the
// output record is all-zero on idle cycles.
module resp_delay_line
    import mem_if_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  valid_i,
    input  resp_t resp_i,
    output logic  valid_o,
    output resp_t resp_o
);

    logic [LAT-1:0] r_valid;
    resp_t          r_resp [LAT];

    // Shift valid/response one stage per clock; reset flushes every stage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_resp[k] <= '0;
            end
        end else begin
            r_valid[0] <= valid_i;
            r_resp[0]  <= valid_i ? resp_i : '0;
            for (int k = 1; k < LAT; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_resp[k]  <= r_resp[k-1];
            end
        end
    end

    assign valid_o = r_valid[LAT-1];
    assign resp_o  = r_resp[LAT-1];

endmodule

// File: rtl/data_bus_responder.sv
// Memory-side responder for the core data bus req/gnt/rvalid protocol.
// Word-organised SRAM model with byte-enable writes, optional grant wait
// states, a fixed response latency and a cap on accepted-but-unanswered
// transactions. Out-of-range accesses complete with err=1.
module data_bus_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH      = DATA_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DATA_WORD_WIDTH,
    parameter int NUM_WORDS       = 1024,
    parameter int GNT_WAIT        = 0,
    parameter int RVALID_LAT      = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int LIM_W = ADDR_WIDTH + 1;
    // The IDLE cycle in which req_i is first seen already counts as one wait
    // cycle, so the WAIT state only has to cover the remaining GNT_WAIT-1.
    localparam int CNT_W = (GNT_WAIT > 2) ? $clog2(GNT_WAIT - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD   = (GNT_WAIT > 2) ? CNT_W'(GNT_WAIT - 2) : '0;
    localparam logic [LIM_W-1:0] ADDR_LIMIT = LIM_W'(NUM_WORDS * 4);

    gnt_state_e           r_state;
    gnt_state_e           w_state_nxt;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic [CNT_W-1:0]     w_wait_cnt_nxt;
    logic [OUT_W-1:0]     r_outstanding;
    logic [OUT_W-1:0]     w_outstanding_nxt;
    logic                 w_full;
    logic                 w_gnt_fsm;
    logic                 w_gnt;
    logic                 w_accept;
    logic                 w_in_range;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_rvalid;
    resp_t                w_resp_in;
    resp_t                w_resp_out;
    logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];

    // A retiring response does not free its slot until the following cycle.
    assign w_full = (r_outstanding == OUT_W'(MAX_OUTSTANDING));

    // Zero wait states grant combinationally; otherwise the FSM decides.
    assign w_gnt    = (GNT_WAIT == 0) ? (rst_ni & req_i & ~w_full)
                                      : (rst_ni & w_gnt_fsm);
    assign w_accept = req_i & w_gnt;
    assign gnt_o    = w_gnt;

    assign w_idx      = addr_i[2 +: IDX_W];
    assign w_in_range = ({1'b0, addr_i} < ADDR_LIMIT);

    // Grant FSM next-state: wait states re-applied for every transaction.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_gnt_fsm      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_i && !w_full) begin
                    if (GNT_WAIT <= 1) begin
                        w_state_nxt = ST_GRANT;
                    end else begin
                        w_state_nxt    = ST_WAIT;
                        w_wait_cnt_nxt = CNT_LOAD;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wait_cnt == '0) begin
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - CNT_W'(1);
                end
            end
            ST_GRANT: begin
                w_gnt_fsm = req_i & ~w_full;
                if (!req_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_gnt_fsm) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // Grant FSM state and wait counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Outstanding count: accept and retire in the same cycle cancel out.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        case ({w_accept, w_rvalid})
            2'b10:   w_outstanding_nxt = r_outstanding + OUT_W'(1);
            2'b01:   w_outstanding_nxt = r_outstanding - OUT_W'(1);
            default: w_outstanding_nxt = r_outstanding;
        endcase
    end

    // Outstanding transaction counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
        end
    end

    // Build the response captured at the accept edge (read sees pre-write data).
    always_comb begin
        w_resp_in = '0;
        if (!w_in_range) begin
            w_resp_in.err   = 1'b1;
            w_resp_in.rdata = we_i ? '0 : ERR_RDATA;
        end else if (we_i) begin
            w_resp_in.rdata = '0;
        end else begin
            w_resp_in.rdata = r_mem[w_idx];
        end
    end

    // Memory array: byte-enable writes on accept, contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_accept && we_i && w_in_range) begin
            r_mem[w_idx] <= merge_bytes(r_mem[w_idx], wdata_i, be_i);
        end
    end

    resp_delay_line #(
        .LAT (RVALID_LAT)
    ) u_resp_delay_line (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (w_accept),
        .resp_i  (w_resp_in),
        .valid_o (w_rvalid),
        .resp_o  (w_resp_out)
    );

    assign rvalid_o = w_rvalid;
    assign rdata_o  = w_resp_out.rdata;
    assign err_o    = w_resp_out.err;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder. Three instances share one stimulus
// bus; each phase checks only the instance whose configuration it targets:
//   a: defaults (GNT_WAIT=0, RVALID_LAT=1, MAX_OUTSTANDING=2)
//   b: GNT_WAIT=3, RVALID_LAT=2
//   c: GNT_WAIT=0, RVALID_LAT=4, MAX_OUTSTANDING=2
module tb_data_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        gnt_a, rv_a, err_a;
    logic [31:0] rd_a;
    logic        gnt_b, rv_b, err_b;
    logic [31:0] rd_b;
    logic        gnt_c, rv_c, err_c;
    logic [31:0] rd_c;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    data_bus_responder u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_a), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rv_a), .rdata_o(rd_a), .err_o(err_a)
    );

    data_bus_responder #(.GNT_WAIT(3), .RVALID_LAT(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_b), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rv_b), .rdata_o(rd_b), .err_o(err_b)
    );

    data_bus_responder #(.RVALID_LAT(4), .MAX_OUTSTANDING(2)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_c), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rv_c), .rdata_o(rd_c), .err_o(err_c)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } a_vec_t;

    a_vec_t avec [16];

    task automatic drv(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
        req   = r;
        we    = w;
        be    = b;
        addr  = a;
        wdata = d;
    endtask

    // Check one cycle of one instance at the falling edge, then move to just after the next rising edge.
    task automatic chk(input int sel, input logic e_gnt, input logic e_rv, input logic e_err,
                       input logic [31:0] e_rd, input string tag);
        logic        g;
        logic        v;
        logic        e;
        logic [31:0] d;
        @(negedge clk);
        case (sel)
            0:       begin g = gnt_a; v = rv_a; e = err_a; d = rd_a; end
            1:       begin g = gnt_b; v = rv_b; e = err_b; d = rd_b; end
            2:       begin g = gnt_c; v = rv_c; e = err_c; d = rd_c; end
            default: begin g = 1'bx;  v = 1'bx; e = 1'bx;  d = 'x;   end
        endcase
        n_vec++;
        if (g !== e_gnt) begin
            n_miss++;
            $display("FAIL %s gnt: got %0b expected %0b", tag, g, e_gnt);
        end
        if (v !== e_rv) begin
            n_miss++;
            $display("FAIL %s rvalid: got %0b expected %0b", tag, v, e_rv);
        end
        if (e !== e_err) begin
            n_miss++;
            $display("FAIL %s err: got %0b expected %0b", tag, e, e_err);
        end
        if (d !== e_rd) begin
            n_miss++;
            $display("FAIL %s rdata: got %h expected %h", tag, d, e_rd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        //             we    be     addr          wdata          err   rdata
        avec[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
        avec[1]  = '{1'b0, 4'h0, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
        avec[2]  = '{1'b1, 4'hF, 32'h0000_0040, 32'h1122_3344, 1'b0, 32'h0000_0000};
        avec[3]  = '{1'b1, 4'h5, 32'h0000_0040, 32'hAABB_CCDD, 1'b0, 32'h0000_0000};
        avec[4]  = '{1'b0, 4'h0, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h11BB_33DD};
        avec[5]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0000_0000};
        avec[6]  = '{1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
        avec[7]  = '{1'b0, 4'h0, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
        avec[8]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1234_5678};
        avec[9]  = '{1'b1, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
        avec[10] = '{1'b0, 4'h0, 32'h0000_0003, 32'h0000_0000, 1'b0, 32'h1234_5678};
        avec[11] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'hA5A5_5A5A, 1'b0, 32'h0000_0000};
        avec[12] = '{1'b0, 4'h0, 32'h0000_0FFE, 32'h0000_0000, 1'b0, 32'hA5A5_5A5A};
        avec[13] = '{1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
        avec[14] = '{1'b1, 4'hA, 32'h0000_0040, 32'h9988_7766, 1'b0, 32'h0000_0000};
        avec[15] = '{1'b0, 4'h0, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h99BB_77DD};

        // Reset: every instance quiet while rst_n is low.
        rst_n = 1'b0;
        drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk(s, 1'b0, 1'b0, 1'b0, 32'h0, $sformatf("reset%0d", s));
        end
        rst_n = 1'b1;

        // Instance a: one transaction per record, grant same cycle, response next cycle.
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, avec[i].we, avec[i].be, avec[i].addr, avec[i].wdata);
            chk(0, 1'b1, 1'b0, 1'b0, 32'h0, $sformatf("a%0d_req", i));
            drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            chk(0, 1'b0, 1'b1, avec[i].exp_err, avec[i].exp_rdata, $sformatf("a%0d_rsp", i));
        end

        // Instance a: read accepted the cycle after a write to the same word.
        drv(1'b1, 1'b1, 4'hF, 32'h0000_0200, 32'h0BAD_F00D);
        chk(0, 1'b1, 1'b0, 1'b0, 32'h0, "raw_wr");
        drv(1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0);
        chk(0, 1'b1, 1'b1, 1'b0, 32'h0, "raw_rd");
        drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk(0, 1'b0, 1'b1, 1'b0, 32'h0BAD_F00D, "raw_rsp");
        chk(0, 1'b0, 1'b0, 1'b0, 32'h0, "raw_idle");
        gap(8);

        // Instance b: three wait cycles, grant in the fourth, rvalid two cycles after accept.
        drv(1'b1, 1'b1, 4'hF, 32'h0000_0008, 32'h5555_AAAA);
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_w0");
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_w1");
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_w2");
        chk(1, 1'b1, 1'b0, 1'b0, 32'h0, "b_w3");
        drv(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_r0");
        chk(1, 1'b0, 1'b1, 1'b0, 32'h0, "b_r1_wrsp");
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_r2");
        chk(1, 1'b1, 1'b0, 1'b0, 32'h0, "b_r3");
        drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_i0");
        chk(1, 1'b0, 1'b1, 1'b0, 32'h5555_AAAA, "b_rrsp");
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_i2");
        // Request withdrawn during the wait: no access, full wait on the retry.
        drv(1'b1, 1'b0, 4'h0, 32'h0000_2000, 32'h0);
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_ab0");
        drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_ab1");
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_ab2");
        drv(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_rr0");
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_rr1");
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_rr2");
        chk(1, 1'b1, 1'b0, 1'b0, 32'h0, "b_rr3");
        drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk(1, 1'b0, 1'b0, 1'b0, 32'h0, "b_rr4");
        chk(1, 1'b0, 1'b1, 1'b0, 32'h5555_AAAA, "b_rr_rsp");
        gap(8);

        // Instance c: outstanding cap of 2 with latency 4, held requests stall while full.
        drv(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hA0A0_0001);
        chk(2, 1'b1, 1'b0, 1'b0, 32'h0, "c00");
        drv(1'b1, 1'b1, 4'hF, 32'h0000_0014, 32'hB0B0_0002);
        chk(2, 1'b1, 1'b0, 1'b0, 32'h0, "c01");
        drv(1'b1, 1'b1, 4'hF, 32'h0000_0018, 32'hC0C0_0003);
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "c02");
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "c03");
        chk(2, 1'b0, 1'b1, 1'b0, 32'h0, "c04");
        chk(2, 1'b1, 1'b1, 1'b0, 32'h0, "c05");
        drv(1'b1, 1'b1, 4'hF, 32'h0000_001C, 32'hD0D0_0004);
        chk(2, 1'b1, 1'b0, 1'b0, 32'h0, "c06");
        drv(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "c07");
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "c08");
        chk(2, 1'b0, 1'b1, 1'b0, 32'h0, "c09");
        chk(2, 1'b1, 1'b1, 1'b0, 32'h0, "c10");
        drv(1'b1, 1'b0, 4'h0, 32'h0000_0014, 32'h0);
        chk(2, 1'b1, 1'b0, 1'b0, 32'h0, "c11");
        drv(1'b1, 1'b0, 4'h0, 32'h0000_0018, 32'h0);
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "c12");
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "c13");
        chk(2, 1'b0, 1'b1, 1'b0, 32'hA0A0_0001, "c14");
        chk(2, 1'b1, 1'b1, 1'b0, 32'hB0B0_0002, "c15");
        drv(1'b1, 1'b0, 4'h0, 32'h0000_001C, 32'h0);
        chk(2, 1'b1, 1'b0, 1'b0, 32'h0, "c16");
        drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "c17");
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "c18");
        chk(2, 1'b0, 1'b1, 1'b0, 32'hC0C0_0003, "c19");
        chk(2, 1'b0, 1'b1, 1'b0, 32'hD0D0_0004, "c20");
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "c21");
        gap(8);

        // Instance c: reset right after an accept drops the pending response.
        drv(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        chk(2, 1'b1, 1'b0, 1'b0, 32'h0, "rst_acc");
        drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "rst_low");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk(2, 1'b0, 1'b0, 1'b0, 32'h0, $sformatf("rst_quiet%0d", i));
        end
        // Counter back at zero: exactly two accepts before the cap bites.
        drv(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        chk(2, 1'b1, 1'b0, 1'b0, 32'h0, "post_rst0");
        drv(1'b1, 1'b0, 4'h0, 32'h0000_0014, 32'h0);
        chk(2, 1'b1, 1'b0, 1'b0, 32'h0, "post_rst1");
        drv(1'b1, 1'b0, 4'h0, 32'h0000_0018, 32'h0);
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "post_rst_full");
        drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "post_rst3");
        chk(2, 1'b0, 1'b1, 1'b0, 32'hA0A0_0001, "post_rst_rsp0");
        chk(2, 1'b0, 1'b1, 1'b0, 32'hB0B0_0002, "post_rst_rsp1");
        chk(2, 1'b0, 1'b0, 1'b0, 32'h0, "post_rst6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
